// File: rtl/fb_pkg.sv
// Shared types and helpers for the framebuffer stream writer.
package fb_pkg;

  typedef enum logic [2:0] {IDLE, POP, LOAD, REQ, WAIT, DONE} fb_state_e;

  localparam logic [3:0] BE_ALL = 4'hF;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Linear framebuffer walker: byte offset counter with frame wrap, frame_done
// pulse and double-buffered base latch.
module fb_addr_gen
  import fb_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = 1228800
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        first_i,
  input  logic        step_i,
  input  logic        fb_sel_i,
  input  logic [31:0] fb_base0_i,
  input  logic [31:0] fb_base1_i,
  output logic [31:0] addr_o,
  output logic        frame_done_o
);

  localparam int unsigned OFF_W = clog2(FRAME_BYTES) + 1;

  logic [OFF_W-1:0] off_q, off_d;
  logic [29:0]      base_q, base_sel;
  logic             started_q, done_q;
  logic             unused_lsb;

  assign base_sel   = fb_sel_i ? fb_base1_i[31:2] : fb_base0_i[31:2];
  assign off_d      = off_q + OFF_W'(4);
  assign unused_lsb = ^{fb_base0_i[1:0], fb_base1_i[1:0]};

  // Reset base is never visible: the first departure from IDLE re-latches it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      off_q     <= '0;
      base_q    <= '0;
      started_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (first_i && !started_q) begin
        base_q    <= base_sel;
        started_q <= 1'b1;
      end
      if (step_i) begin
        if (off_d == OFF_W'(FRAME_BYTES)) begin
          off_q  <= '0;
          done_q <= 1'b1;
          base_q <= base_sel;
        end else begin
          off_q <= off_d;
        end
      end
    end
  end

  assign addr_o       = {base_q, 2'b00} + 32'(off_q);
  assign frame_done_o = done_q;

endmodule

// File: rtl/fb_stream_writer.sv
// PLB IPIF master framebuffer writer: pops FIFO words, splits them into 32-bit
// single-beat writes (most significant beat first) and walks a wrapping frame.
module fb_stream_writer
  import fb_pkg::*;
#(
  parameter int unsigned FIFO_W      = 64,
  parameter int unsigned FRAME_BYTES = 1228800,
  parameter int unsigned ERR_CNT_W   = 8
) (
  input  logic                 PLB_clk,
  input  logic                 PLB_resetn,
  input  logic                 enable,
  input  logic [31:0]          fb_base0,
  input  logic [31:0]          fb_base1,
  input  logic                 fb_sel,
  input  logic [FIFO_W-1:0]    fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  output logic                 IP2Bus_MstRd_Req,
  output logic                 IP2Bus_MstWr_Req,
  output logic [31:0]          IP2Bus_Mst_Addr,
  output logic [3:0]           IP2Bus_Mst_BE,
  output logic                 IP2Bus_Mst_Lock,
  output logic                 IP2Bus_Mst_Reset,
  output logic [31:0]          IP2Bus_MstWr_d,
  input  logic                 Bus2IP_Mst_CmdAck,
  input  logic                 Bus2IP_Mst_Cmplt,
  input  logic                 Bus2IP_Mst_Error,
  input  logic                 Bus2IP_Mst_Rearbitrate,
  input  logic                 Bus2IP_Mst_Cmd_Timeout,
  input  logic [31:0]          Bus2IP_MstRd_d,
  input  logic                 Bus2IP_MstRd_src_rdy_n,
  input  logic                 Bus2IP_MstWr_dst_rdy_n,
  output logic                 frame_done,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int unsigned NB     = FIFO_W / 32;
  localparam int unsigned BEAT_W = (NB > 1) ? clog2(NB) : 1;

  fb_state_e               state_q;
  logic [BEAT_W-1:0]       beat_q, beat_idx;
  logic [NB-1:0][31:0]     word_q, word_src;
  logic                    rd_en_q, req_q;
  logic [31:0]             addr_q, wr_d_q, beat_addr;
  logic [ERR_CNT_W-1:0]    err_q, err_d;
  logic                    go, retry, last_beat, unused_in;

  assign go        = enable & ~fifo_empty;
  assign retry     = Bus2IP_Mst_Rearbitrate | Bus2IP_Mst_Cmd_Timeout;
  assign last_beat = (beat_q == BEAT_W'(NB - 1));
  assign err_d     = (Bus2IP_Mst_Error && err_q != '1) ? err_q + ERR_CNT_W'(1) : err_q;
  assign unused_in = ^{Bus2IP_MstRd_d, Bus2IP_MstRd_src_rdy_n, Bus2IP_MstWr_dst_rdy_n};

  // Beat 0 is issued straight from the FIFO output while it is being captured.
  assign word_src = (beat_q == '0) ? fifo_data : word_q;
  assign beat_idx = BEAT_W'(NB - 1) - beat_q;

  fb_addr_gen #(.FRAME_BYTES(FRAME_BYTES)) u_addr (
    .clk_i        (PLB_clk),
    .rst_ni       (PLB_resetn),
    .first_i      (state_q == IDLE && go),
    .step_i       (state_q == DONE),
    .fb_sel_i     (fb_sel),
    .fb_base0_i   (fb_base0),
    .fb_base1_i   (fb_base1),
    .addr_o       (beat_addr),
    .frame_done_o (frame_done)
  );

  always_ff @(posedge PLB_clk or negedge PLB_resetn) begin
    if (!PLB_resetn) begin
      state_q <= IDLE;
      beat_q  <= '0;
      word_q  <= '0;
      rd_en_q <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wr_d_q  <= '0;
      err_q   <= '0;
    end else begin
      rd_en_q <= 1'b0;
      case (state_q)
        IDLE: if (go) begin
          rd_en_q <= 1'b1;
          state_q <= POP;
        end
        POP: begin
          beat_q  <= '0;
          state_q <= LOAD;
        end
        LOAD: begin
          if (beat_q == '0) word_q <= fifo_data;
          addr_q  <= beat_addr;
          wr_d_q  <= word_src[beat_idx];
          req_q   <= 1'b1;
          state_q <= REQ;
        end
        REQ: begin
          if (Bus2IP_Mst_CmdAck && Bus2IP_Mst_Cmplt) begin
            req_q   <= 1'b0;
            err_q   <= err_d;
            state_q <= DONE;
          end else if (retry) begin
            req_q <= 1'b1;
          end else if (Bus2IP_Mst_CmdAck) begin
            req_q   <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (Bus2IP_Mst_Cmplt) begin
            err_q   <= err_d;
            state_q <= DONE;
          end else if (retry) begin
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        DONE: begin
          if (!last_beat) begin
            beat_q  <= beat_q + BEAT_W'(1);
            state_q <= LOAD;
          end else if (go) begin
            rd_en_q <= 1'b1;
            state_q <= POP;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_rd_en       = rd_en_q;
  assign IP2Bus_MstRd_Req = 1'b0;
  assign IP2Bus_MstWr_Req = req_q;
  assign IP2Bus_Mst_Addr  = addr_q;
  assign IP2Bus_Mst_BE    = BE_ALL;
  assign IP2Bus_Mst_Lock  = 1'b0;
  assign IP2Bus_Mst_Reset = 1'b0;
  assign IP2Bus_MstWr_d   = wr_d_q;
  assign busy             = (state_q != IDLE);
  assign err_cnt          = err_q;

endmodule

// File: tb/tb_fb_stream_writer.sv
// Randomized bench: FIFO and IPIF slave models drive the writer; a frame-level
// reference predicts every completed beat's address and data.
module tb_fb_stream_writer;

  localparam int unsigned FIFO_W      = 64;
  localparam int unsigned FRAME_BYTES = 16;
  localparam int unsigned ERR_CNT_W   = 8;

  logic              PLB_clk = 1'b0;
  logic              PLB_resetn, enable, fb_sel, fifo_empty, fifo_rd_en;
  logic [31:0]       fb_base0, fb_base1;
  logic [FIFO_W-1:0] fifo_data;
  logic              IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Lock, IP2Bus_Mst_Reset;
  logic [31:0]       IP2Bus_Mst_Addr, IP2Bus_MstWr_d;
  logic [3:0]        IP2Bus_Mst_BE;
  logic              Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error;
  logic              Bus2IP_Mst_Rearbitrate, Bus2IP_Mst_Cmd_Timeout;
  logic [31:0]       Bus2IP_MstRd_d;
  logic              Bus2IP_MstRd_src_rdy_n, Bus2IP_MstWr_dst_rdy_n;
  logic              frame_done, busy;
  logic [ERR_CNT_W-1:0] err_cnt;

  always #5 PLB_clk = ~PLB_clk;

  fb_stream_writer #(.FIFO_W(FIFO_W), .FRAME_BYTES(FRAME_BYTES), .ERR_CNT_W(ERR_CNT_W)) dut (
    .PLB_clk(PLB_clk), .PLB_resetn(PLB_resetn), .enable(enable),
    .fb_base0(fb_base0), .fb_base1(fb_base1), .fb_sel(fb_sel),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .IP2Bus_MstRd_Req(IP2Bus_MstRd_Req), .IP2Bus_MstWr_Req(IP2Bus_MstWr_Req),
    .IP2Bus_Mst_Addr(IP2Bus_Mst_Addr), .IP2Bus_Mst_BE(IP2Bus_Mst_BE),
    .IP2Bus_Mst_Lock(IP2Bus_Mst_Lock), .IP2Bus_Mst_Reset(IP2Bus_Mst_Reset),
    .IP2Bus_MstWr_d(IP2Bus_MstWr_d),
    .Bus2IP_Mst_CmdAck(Bus2IP_Mst_CmdAck), .Bus2IP_Mst_Cmplt(Bus2IP_Mst_Cmplt),
    .Bus2IP_Mst_Error(Bus2IP_Mst_Error), .Bus2IP_Mst_Rearbitrate(Bus2IP_Mst_Rearbitrate),
    .Bus2IP_Mst_Cmd_Timeout(Bus2IP_Mst_Cmd_Timeout), .Bus2IP_MstRd_d(Bus2IP_MstRd_d),
    .Bus2IP_MstRd_src_rdy_n(Bus2IP_MstRd_src_rdy_n),
    .Bus2IP_MstWr_dst_rdy_n(Bus2IP_MstWr_dst_rdy_n),
    .frame_done(frame_done), .busy(busy), .err_cnt(err_cnt)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  // Reference state
  logic [63:0] fifo_q[$];
  logic [31:0] exp_d[$];
  logic [31:0] m_base;
  int unsigned m_off;
  int          m_frames = 0, frames_seen = 0, m_errs = 0, pops = 0, pushed = 0;
  bit          fill_en, en_prev, empty_prev, pend;
  logic [63:0] pend_word;
  int          en_pct, gate_pct, rearb_pct, err_pct;
  int          ph, ack_dly, cmp_dly;

  function automatic logic [31:0] sel_base();
    return (fb_sel ? fb_base1 : fb_base0) & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [63:0] exp_err();
    return (m_errs > 255) ? 64'd255 : 64'(m_errs);
  endfunction

  task automatic new_dly();
    ack_dly = int'($urandom_range(2));
    cmp_dly = int'($urandom_range(3));
  endtask

  task automatic bus_idle();
    Bus2IP_Mst_CmdAck = 0; Bus2IP_Mst_Cmplt = 0; Bus2IP_Mst_Error = 0;
    Bus2IP_Mst_Rearbitrate = 0; Bus2IP_Mst_Cmd_Timeout = 0;
  endtask

  task automatic model_reset();
    exp_d.delete();
    m_off  = 0;
    m_base = sel_base();
    m_errs = 0;
    ph     = 0;
    pend   = 0;
    new_dly();
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_wr_req"}, IP2Bus_MstWr_Req, 0);
    chk({p, "_rd_en"},  fifo_rd_en, 0);
    chk({p, "_addr"},   IP2Bus_Mst_Addr, 0);
    chk({p, "_wr_d"},   IP2Bus_MstWr_d, 0);
    chk({p, "_be"},     IP2Bus_Mst_BE, 4'hF);
    chk({p, "_busy"},   busy, 0);
    chk({p, "_fdone"},  frame_done, 0);
    chk({p, "_err"},    err_cnt, 0);
    chk({p, "_ties"},   {IP2Bus_MstRd_Req, IP2Bus_Mst_Lock, IP2Bus_Mst_Reset}, 0);
  endtask

  // Called on the cycle a beat completes: address follows base+offset with wrap.
  task automatic complete();
    logic [31:0] ea;
    chk("beat_expected", 64'(exp_d.size() != 0), 1);
    if (exp_d.size() != 0) begin
      ea = m_base + m_off;
      chk("addr", IP2Bus_Mst_Addr, ea);
      chk("data", IP2Bus_MstWr_d, exp_d.pop_front());
      if (Bus2IP_Mst_Error) m_errs++;
      if (m_off == 4 && $urandom_range(1) == 1) fb_sel = ~fb_sel;
      m_off += 4;
      if (m_off == FRAME_BYTES) begin
        m_off = 0;
        m_frames++;
        m_base = sel_base();
      end
    end
  endtask

  task automatic cyc();
    logic [63:0] w;
    @(negedge PLB_clk);
    bus_idle();
    if (frame_done) frames_seen++;
    if (pend) begin
      fifo_data = pend_word;
      pend = 0;
    end
    if (fifo_rd_en) begin
      chk("pop_word_in_flight", 64'(exp_d.size()), 0);
      chk("pop_cond", {62'd0, en_prev, empty_prev}, 64'd2);
      chk("pop_has_data", 64'(fifo_q.size() != 0), 1);
      if (fifo_q.size() != 0) begin
        w = fifo_q.pop_front();
        pend_word = w;
        pend = 1;
        fifo_data = ~w;
        exp_d.push_back(w[63:32]);
        exp_d.push_back(w[31:0]);
        pops++;
      end
    end
    if (ph == 0 && IP2Bus_MstWr_Req) begin
      if (ack_dly > 0) begin
        ack_dly--;
        if ($urandom_range(99) < rearb_pct) begin
          if ($urandom_range(1) == 1) Bus2IP_Mst_Rearbitrate = 1;
          else Bus2IP_Mst_Cmd_Timeout = 1;
        end
      end else begin
        Bus2IP_Mst_CmdAck = 1;
        if (cmp_dly == 0) begin
          Bus2IP_Mst_Cmplt = 1;
          Bus2IP_Mst_Error = ($urandom_range(99) < err_pct);
          complete();
          new_dly();
        end else begin
          ph = 1;
        end
      end
    end else if (ph == 1) begin
      chk("req_low_in_wait", IP2Bus_MstWr_Req, 0);
      if (cmp_dly > 1) begin
        cmp_dly--;
        if ($urandom_range(99) < rearb_pct) begin
          Bus2IP_Mst_Rearbitrate = 1;
          ph = 0;
          new_dly();
        end
      end else begin
        Bus2IP_Mst_Cmplt = 1;
        Bus2IP_Mst_Error = ($urandom_range(99) < err_pct);
        complete();
        ph = 0;
        new_dly();
      end
    end
    if (fill_en && fifo_q.size() < 3) begin
      fifo_q.push_back({$urandom, $urandom});
      pushed++;
    end
    enable     = ($urandom_range(99) < en_pct);
    fifo_empty = (fifo_q.size() == 0) || ($urandom_range(99) < gate_pct);
    en_prev    = enable;
    empty_prev = fifo_empty;
  endtask

  task automatic drain(input string p);
    int n;
    n = 0;
    fill_en = 0; en_pct = 100; gate_pct = 0;
    while ((fifo_q.size() != 0 || pend || exp_d.size() != 0 || busy) && n < 3000) begin
      cyc();
      n++;
    end
    chk({p, "_drained"}, 64'(n < 3000), 1);
  endtask

  task automatic reset_in_wait();
    int n;
    n = 0;
    while (ph != 1 && n < 2000) begin
      cyc();
      n++;
    end
    chk("wait_reached", 64'(ph == 1), 1);
    #7;
    chk("busy_before_rst", busy, 1);
    chk("req_before_rst", IP2Bus_MstWr_Req, 0);
    PLB_resetn = 0;
    bus_idle();
    #1;
    chk_reset_vals("rst_wait");
    model_reset();
    repeat (2) @(negedge PLB_clk);
    PLB_resetn = 1;
  endtask

  initial begin
    int n;
    PLB_resetn = 0; enable = 0; fb_sel = 0; fifo_empty = 1; fifo_data = '0;
    fb_base0 = 32'h0000_1003; fb_base1 = 32'h0008_2002;
    Bus2IP_MstRd_d = 32'hDEAD_BEEF; Bus2IP_MstRd_src_rdy_n = 1; Bus2IP_MstWr_dst_rdy_n = 0;
    bus_idle();
    fifo_q.push_back(64'h0011223344556677);
    pushed = 1;
    fill_en = 1;
    en_pct = 80; gate_pct = 20; rearb_pct = 15; err_pct = 25;
    en_prev = 0; empty_prev = 1;
    repeat (3) @(negedge PLB_clk);
    chk_reset_vals("rst");
    model_reset();
    PLB_resetn = 1;

    repeat (600) cyc();
    reset_in_wait();

    fill_en = 1; en_pct = 50; gate_pct = 30;
    repeat (600) cyc();
    drain("b");
    chk("err_cnt_b", err_cnt, exp_err());
    chk("frames_b", 64'(frames_seen), 64'(m_frames));

    fill_en = 1; en_pct = 90; gate_pct = 10; err_pct = 100; rearb_pct = 10;
    n = 0;
    while (m_errs < 300 && n < 20000) begin
      cyc();
      n++;
    end
    chk("errs_reached", 64'(m_errs >= 300), 1);
    drain("c");
    chk("err_cnt_sat", err_cnt, exp_err());
    chk("frames", 64'(frames_seen), 64'(m_frames));
    chk("pops", 64'(pops), 64'(pushed));
    repeat (4) cyc();
    chk("idle_busy", busy, 0);
    chk("idle_req", IP2Bus_MstWr_Req, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
